// File: rtl/mem_requester.sv
// mem_requester
// Processor-side initiator for the KV10 memory bus. Accepts one single-word
// read or write from the execution unit, holds the bus strobe, address, data
// and user-space select steady until the responder acknowledges, returns the
// read data, then waits for the acknowledge to fall before taking the next
// request. If no acknowledge arrives within TIMEOUT strobe cycles, the access
// completes with a nonexistent-memory (NXM) fault.
//
// Parameters
//   ADDR     word address width (18 for KV10)
//   WORD     data word width (36 for KV10)
//   TIMEOUT  strobe cycles without mem_ack before NXM, 1..65535
//
// Ports
//   clk, reset_n           rising-edge clock, async active-low reset
//   req_valid/req_ready    request handshake (ready only in IDLE)
//   req_write              1 = write, 0 = read
//   req_addr/data/user     request fields
//   rsp_valid              one-cycle completion pulse
//   rsp_nxm                qualifies rsp_valid: access timed out
//   rsp_data               last read data, held until the next read completes
//   mem_addr/write_data/user  registered request fields driven to the bus
//   mem_read/mem_write     mutually exclusive bus strobes
//   mem_ack                responder completion
//   mem_read_data          responder read data, valid while mem_ack is high
module mem_requester #(
    parameter int ADDR    = 18,
    parameter int WORD    = 36,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [ADDR-1:0] req_addr,
    input  logic [WORD-1:0] req_data,
    input  logic            req_user,
    output logic            rsp_valid,
    output logic [WORD-1:0] rsp_data,
    output logic            rsp_nxm,
    output logic [ADDR-1:0] mem_addr,
    output logic [WORD-1:0] mem_write_data,
    output logic            mem_user,
    output logic            mem_read,
    output logic            mem_write,
    input  logic            mem_ack,
    input  logic [WORD-1:0] mem_read_data
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    // Counter value seen on the last strobe cycle before NXM is declared.
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [ADDR-1:0] addr_q, addr_d;
    logic [WORD-1:0] wdata_q, wdata_d;
    logic            user_q, user_d;
    logic            rd_q, rd_d;
    logic            wr_q, wr_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_nxm_q, rsp_nxm_d;
    logic [WORD-1:0] rsp_data_q, rsp_data_d;

    // Next-state logic for the access sequencer and all registered outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        user_d      = user_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        rsp_valid_d = 1'b0;
        rsp_nxm_d   = 1'b0;
        rsp_data_d  = rsp_data_q;

        case (state_q)
            ST_IDLE: begin
                // mem_ack is ignored here; only a new request matters.
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_data;
                    user_d  = req_user;
                    rd_d    = !req_write;
                    wr_d    = req_write;
                    cnt_d   = 16'd0;
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_BUSY: begin
                // Ack is tested first so it wins over a simultaneous timeout.
                if (mem_ack) begin
                    rd_d        = 1'b0;
                    wr_d        = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RELEASE;
                    if (rd_q) begin
                        rsp_data_d = mem_read_data;
                    end else begin
                        rsp_data_d = rsp_data_q;
                    end
                end else if (cnt_q == TIMEOUT_LAST) begin
                    rd_d        = 1'b0;
                    wr_d        = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_nxm_d   = 1'b1;
                    state_d     = ST_RELEASE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            ST_RELEASE: begin
                // Wait out a sticky ack so it cannot complete the next access.
                if (mem_ack) begin
                    state_d = ST_RELEASE;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 16'd0;
            addr_q      <= '0;
            wdata_q     <= '0;
            user_q      <= 1'b0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_nxm_q   <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            user_q      <= user_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_nxm_q   <= rsp_nxm_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign req_ready      = (state_q == ST_IDLE);
    assign mem_addr       = addr_q;
    assign mem_write_data = wdata_q;
    assign mem_user       = user_q;
    assign mem_read       = rd_q;
    assign mem_write      = wr_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_nxm        = rsp_nxm_q;
    assign rsp_data       = rsp_data_q;

endmodule
